// File: rtl/correlator_pkg.sv
`default_nettype none
// ============================================================================
// correlator_pkg: types and constants shared by the visibility readout path.
// Revision: 1.0
// ============================================================================
package correlator_pkg;

  localparam int VIS_BANKS = 2;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_LOAD = 2'd1,
    RD_REAL = 2'd2,
    RD_IMAG = 2'd3
  } rd_state_e;

  // Index width for n entries, never narrower than one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vis_pingpong_ram.sv
`default_nettype none
// ============================================================================
// vis_pingpong_ram: two-bank {re,im} visibility store, 1 write / 1 registered read.
// Revision: 1.0
// ============================================================================
module vis_pingpong_ram
  import correlator_pkg::*;
#(
  parameter int IBITS = 7,
  parameter int PSUMS = 3,
  parameter int EW    = idx_bits(PSUMS)
) (
  input  logic               clock,
  input  logic               we_i,
  input  logic               wbank_i,
  input  logic [EW-1:0]      wadr_i,
  input  logic [2*IBITS-1:0] wdata_i,
  input  logic               re_i,
  input  logic               rbank_i,
  input  logic [EW-1:0]      radr_i,
  output logic [2*IBITS-1:0] rdata_o
);

  logic [2*IBITS-1:0] mem_q [VIS_BANKS][PSUMS];
  logic [2*IBITS-1:0] rdata_q;

  // Read data is held between reads so the stream side sees a stable word.
  always_ff @(posedge clock) begin
    if (we_i) mem_q[wbank_i][wadr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[rbank_i][radr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/visreadout.sv
`default_nettype none
// ============================================================================
// visreadout: captures visibility blocks into a ping-pong RAM, replays them on AXI4-Stream.
// Revision: 1.0
// ============================================================================
module visreadout
  import correlator_pkg::*;
#(
  parameter int IBITS = 7,
  parameter int PSUMS = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             frame_i,
  input  logic             valid_i,
  input  logic             first_i,
  input  logic             last_i,
  input  logic [IBITS-1:0] rdata_i,
  input  logic [IBITS-1:0] idata_i,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             m_tuser,
  output logic [IBITS-1:0] m_tdata,
  output logic             drop_o,
  output logic             len_err_o
);

  localparam int EW = idx_bits(PSUMS);
  localparam int AW = idx_bits(PSUMS + 1);

  logic [VIS_BANKS-1:0] full_q;
  logic                 wr_sel_q, wr_sel_d;
  logic                 rd_sel_q;
  logic                 wr_active_q, wr_active_d;
  logic [AW-1:0]        wr_adr_q, wr_adr_d;
  logic                 drop_q, drop_d;
  logic                 len_err_q, len_err_d;
  logic                 w_beat, w_we, w_commit, w_free, w_rd_en;
  logic [EW-1:0]        w_wadr;
  logic [2*IBITS-1:0]   w_rdata;

  rd_state_e            state_q;
  logic [EW-1:0]        rd_adr_q;
  logic                 m_tvalid_q, m_tlast_q, m_tuser_q;

  assign w_beat = valid_i & frame_i;

  // Writes always target wr_sel: commits and frees both alternate banks, so the
  // next bank in commit order is the oldest free one whenever any bank is free.
  always_comb begin
    wr_active_d = wr_active_q;
    wr_adr_d    = wr_adr_q;
    wr_sel_d    = wr_sel_q;
    drop_d      = 1'b0;
    len_err_d   = 1'b0;
    w_we        = 1'b0;
    w_wadr      = wr_adr_q[EW-1:0];
    w_commit    = 1'b0;
    if (wr_active_q && !frame_i) begin
      wr_active_d = 1'b0;
      len_err_d   = 1'b1;
    end else if (w_beat) begin
      if (first_i) begin
        if (!wr_active_q && full_q[wr_sel_q]) begin
          drop_d = 1'b1;
        end else begin
          len_err_d   = wr_active_q;
          w_we        = 1'b1;
          w_wadr      = '0;
          wr_adr_d    = AW'(1);
          wr_active_d = 1'b1;
          if (last_i) begin
            wr_active_d = 1'b0;
            if (PSUMS == 1) w_commit = 1'b1;
            else            len_err_d = 1'b1;
          end
        end
      end else if (wr_active_q) begin
        if (wr_adr_q == AW'(PSUMS)) begin
          wr_active_d = 1'b0;
          len_err_d   = 1'b1;
        end else begin
          w_we     = 1'b1;
          wr_adr_d = wr_adr_q + AW'(1);
          if (last_i) begin
            wr_active_d = 1'b0;
            if (wr_adr_q == AW'(PSUMS - 1)) w_commit = 1'b1;
            else                            len_err_d = 1'b1;
          end
        end
      end
    end
    if (w_commit) wr_sel_d = ~wr_sel_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_active_q <= 1'b0;
      wr_adr_q    <= '0;
      wr_sel_q    <= 1'b0;
      drop_q      <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      wr_active_q <= wr_active_d;
      wr_adr_q    <= wr_adr_d;
      wr_sel_q    <= wr_sel_d;
      drop_q      <= drop_d;
      len_err_q   <= len_err_d;
    end
  end

  assign w_free = (state_q == RD_IMAG) && m_tready && m_tlast_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      full_q   <= '0;
      rd_sel_q <= 1'b0;
    end else begin
      if (w_commit) full_q[wr_sel_q] <= 1'b1;
      if (w_free) begin
        full_q[rd_sel_q] <= 1'b0;
        rd_sel_q         <= ~rd_sel_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RD_IDLE;
      rd_adr_q   <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tuser_q  <= 1'b0;
    end else begin
      case (state_q)
        RD_IDLE: if (full_q[rd_sel_q]) begin
          rd_adr_q <= '0;
          state_q  <= RD_LOAD;
        end
        RD_LOAD: begin
          state_q    <= RD_REAL;
          m_tvalid_q <= 1'b1;
          m_tuser_q  <= (rd_adr_q == '0);
        end
        RD_REAL: if (m_tready) begin
          state_q   <= RD_IMAG;
          m_tuser_q <= 1'b0;
          m_tlast_q <= (rd_adr_q == EW'(PSUMS - 1));
        end
        RD_IMAG: if (m_tready) begin
          m_tvalid_q <= 1'b0;
          m_tlast_q  <= 1'b0;
          if (m_tlast_q) begin
            state_q <= RD_IDLE;
          end else begin
            rd_adr_q <= rd_adr_q + EW'(1);
            state_q  <= RD_LOAD;
          end
        end
        default: state_q <= RD_IDLE;
      endcase
    end
  end

  assign w_rd_en = (state_q == RD_LOAD);

  vis_pingpong_ram #(
    .IBITS (IBITS),
    .PSUMS (PSUMS),
    .EW    (EW)
  ) u_ram (
    .clock   (clock),
    .we_i    (w_we),
    .wbank_i (wr_sel_q),
    .wadr_i  (w_wadr),
    .wdata_i ({rdata_i, idata_i}),
    .re_i    (w_rd_en),
    .rbank_i (rd_sel_q),
    .radr_i  (rd_adr_q),
    .rdata_o (w_rdata)
  );

  // Payload comes straight from the held RAM word; the state picks the half.
  assign m_tdata   = (state_q == RD_IMAG) ? w_rdata[IBITS-1:0] : w_rdata[2*IBITS-1:IBITS];
  assign m_tvalid  = m_tvalid_q;
  assign m_tlast   = m_tlast_q;
  assign m_tuser   = m_tuser_q;
  assign drop_o    = drop_q;
  assign len_err_o = len_err_q;

endmodule
`default_nettype wire

// File: tb/tb_visreadout.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_visreadout: directed and randomized block traffic against a queue model.
// Revision: 1.0
// ============================================================================
module tb_visreadout;

  localparam int IBITS = 7;
  localparam int PSUMS = 3;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             frame_i = 1'b0, valid_i = 1'b0, first_i = 1'b0, last_i = 1'b0;
  logic [IBITS-1:0] rdata_i = '0, idata_i = '0;
  logic             m_tvalid, m_tlast, m_tuser;
  logic             m_tready = 1'b0;
  logic [IBITS-1:0] m_tdata;
  logic             drop_o, len_err_o;

  int tests = 0, fails = 0;

  // Model: a block is accepted if fewer than two blocks are waiting or streaming.
  int             accepted = 0, freed = 0;
  bit             last_pending = 1'b0;
  logic [8:0]     expq[$];
  int             exp_drop = 0, exp_lenerr = 0;
  int             drop_cnt = 0, lenerr_cnt = 0, hs_count = 0;
  bit             prev_stall = 1'b0;
  logic [8:0]     prev_beat = '0;
  int             rdy_mode = 0;
  logic [IBITS-1:0] blk_re[PSUMS], blk_im[PSUMS];

  visreadout #(.IBITS(IBITS), .PSUMS(PSUMS)) dut (
    .clock     (clock),
    .reset     (reset),
    .frame_i   (frame_i),
    .valid_i   (valid_i),
    .first_i   (first_i),
    .last_i    (last_i),
    .rdata_i   (rdata_i),
    .idata_i   (idata_i),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .m_tuser   (m_tuser),
    .m_tdata   (m_tdata),
    .drop_o    (drop_o),
    .len_err_o (len_err_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: protocol stability, beat order against the model, pulse counts.
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (drop_o)    drop_cnt++;
      if (len_err_o) lenerr_cnt++;
      if (prev_stall) begin
        check("stall_tvalid", {31'd0, m_tvalid}, 32'd1);
        check("stall_payload", {23'd0, m_tuser, m_tlast, m_tdata}, {23'd0, prev_beat});
      end
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = {m_tuser, m_tlast, m_tdata};
      if (m_tvalid && m_tready) begin
        hs_count++;
        check("beat_expected", {31'd0, expq.size() != 0}, 32'd1);
        if (expq.size() != 0) begin
          check("beat", {23'd0, m_tuser, m_tlast, m_tdata}, {23'd0, expq.pop_front()});
          if (m_tlast) last_pending = 1'b1;
        end
      end
    end
  end

  always @(posedge clock) begin
    if (last_pending) begin
      freed++;
      last_pending = 1'b0;
    end
  end

  initial forever begin
    @(posedge clock); #1;
    case (rdy_mode)
      0: m_tready = 1'b0;
      1: m_tready = 1'b1;
      2: m_tready = ~m_tready;
      3: m_tready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  task automatic idle_inputs();
    frame_i = 1'b0; valid_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic beat(input bit fi, input bit la, input logic [IBITS-1:0] r, input logic [IBITS-1:0] im);
    frame_i = 1'b1; valid_i = 1'b1; first_i = fi; last_i = la;
    rdata_i = r; idata_i = im;
    @(posedge clock); #1;
  endtask

  task automatic random_data();
    for (int k = 0; k < PSUMS; k++) begin
      blk_re[k] = IBITS'($urandom_range(0, (1 << IBITS) - 1));
      blk_im[k] = IBITS'($urandom_range(0, (1 << IBITS) - 1));
    end
  endtask

  // Sends entries 0..last_at; last_at == PSUMS-1 is a well-formed block.
  task automatic send_block(input int last_at);
    if (accepted - freed >= 2) begin
      exp_drop++;
    end else if (last_at == PSUMS - 1) begin
      accepted++;
      for (int k = 0; k < PSUMS; k++) begin
        expq.push_back({1'(k == 0), 1'b0, blk_re[k]});
        expq.push_back({1'b0, 1'(k == PSUMS - 1), blk_im[k]});
      end
    end else begin
      exp_lenerr++;
    end
    for (int k = 0; k <= last_at; k++) beat(k == 0, k == last_at, blk_re[k], blk_im[k]);
    idle_inputs();
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((expq.size() != 0 || m_tvalid) && n < 400) begin
      @(posedge clock); #1;
      n++;
    end
    check({tag, "_drain_in_time"}, {31'd0, n < 400}, 32'd1);
    repeat (3) begin @(posedge clock); #1; end
  endtask

  initial begin
    int h0, d0, l0, n, la;

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_tlast", {31'd0, m_tlast}, 32'd0);
    check("rst_tuser", {31'd0, m_tuser}, 32'd0);
    check("rst_drop", {31'd0, drop_o}, 32'd0);
    check("rst_lenerr", {31'd0, len_err_o}, 32'd0);

    // 1: fixed block (1,-1),(2,-2),(3,-3) with tready held high
    for (int k = 0; k < PSUMS; k++) begin
      blk_re[k] = IBITS'(k + 1);
      blk_im[k] = IBITS'(-(k + 1));
    end
    rdy_mode = 1;
    h0 = hs_count;
    send_block(PSUMS - 1);
    wait_drain("s1");
    check("s1_beats", hs_count - h0, 2 * PSUMS);

    // 2: same block with tready toggling
    rdy_mode = 2;
    h0 = hs_count;
    send_block(PSUMS - 1);
    wait_drain("s2");
    check("s2_beats", hs_count - h0, 2 * PSUMS);

    // 3: three back-to-back blocks while the sink is stalled
    rdy_mode = 0;
    d0 = drop_cnt;
    for (int b = 0; b < 3; b++) begin
      random_data();
      send_block(PSUMS - 1);
    end
    repeat (2) begin @(posedge clock); #1; end
    check("s3_drop", drop_cnt - d0, 1);
    rdy_mode = 1;
    wait_drain("s3");

    // 4: last_i on entry 1, then a good block
    l0 = lenerr_cnt;
    h0 = hs_count;
    random_data();
    send_block(1);
    random_data();
    send_block(PSUMS - 1);
    wait_drain("s4");
    check("s4_lenerr", lenerr_cnt - l0, 1);
    check("s4_beats", hs_count - h0, 2 * PSUMS);

    // 5: frame_i drops after entry 0; both banks must still accept blocks
    l0 = lenerr_cnt;
    d0 = drop_cnt;
    random_data();
    beat(1'b1, 1'b0, blk_re[0], blk_im[0]);
    exp_lenerr++;
    idle_inputs();
    @(posedge clock); #1;
    rdy_mode = 0;
    for (int b = 0; b < 2; b++) begin
      random_data();
      send_block(PSUMS - 1);
    end
    repeat (2) begin @(posedge clock); #1; end
    check("s5_lenerr", lenerr_cnt - l0, 1);
    check("s5_nodrop", drop_cnt - d0, 0);
    rdy_mode = 1;
    wait_drain("s5");

    // 6: reset while the imag beat of entry 1 is presented
    rdy_mode = 1;
    h0 = hs_count;
    random_data();
    send_block(PSUMS - 1);
    n = 0;
    while (hs_count < h0 + 3 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    rdy_mode = 4;
    m_tready = 1'b0;
    check("s6_reach_imag1", {31'd0, n < 100}, 32'd1);
    @(posedge clock); #1;
    check("s6_tvalid", {31'd0, m_tvalid}, 32'd1);
    check("s6_tlast", {31'd0, m_tlast}, 32'd0);
    check("s6_tdata", {25'd0, m_tdata}, {25'd0, blk_im[1]});
    reset = 1'b1;
    expq.delete();
    @(posedge clock); #1;
    check("s6_rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("s6_rst_tuser", {31'd0, m_tuser}, 32'd0);
    reset = 1'b0;
    accepted = 0;
    freed = 0;
    last_pending = 1'b0;
    rdy_mode = 0;
    d0 = drop_cnt;
    for (int b = 0; b < 2; b++) begin
      random_data();
      send_block(PSUMS - 1);
    end
    repeat (2) begin @(posedge clock); #1; end
    check("s6_banks_free", drop_cnt - d0, 0);
    rdy_mode = 1;
    wait_drain("s6");

    // Randomized traffic: random gaps, payloads, sink readiness, some short blocks
    rdy_mode = 3;
    for (int it = 0; it < 24; it++) begin
      repeat ($urandom_range(0, 4)) begin @(posedge clock); #1; end
      random_data();
      la = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, PSUMS - 2)) : PSUMS - 1;
      send_block(la);
    end
    rdy_mode = 1;
    wait_drain("rnd");

    check("total_drop", drop_cnt, exp_drop);
    check("total_lenerr", lenerr_cnt, exp_lenerr);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
